// File: rtl/gsim_ctrl.sv
// Sequencer for an iterative Gauss-Seidel solver. It loads b, requests
// N_ITER sweeps of single-element updates, then streams the solution vector out.
module gsim_ctrl #(
  parameter int N_ELEM = 16,
  parameter int N_ITER = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] b_in,
  output logic        b_wr_en,
  output logic [3:0]  b_wr_addr,
  output logic [15:0] b_wr_data,
  output logic        upd_req,
  output logic [3:0]  upd_idx,
  input  logic        upd_ack,
  output logic        x_rd_en,
  output logic [3:0]  x_rd_addr,
  input  logic [31:0] x_rd_data,
  output logic        out_valid,
  output logic [31:0] x_out,
  output logic        busy,
  output logic [7:0]  iter_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SWEEP = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0] LAST_IDX  = 4'(N_ELEM - 1);
  localparam logic [7:0] LAST_ITER = 8'(N_ITER - 1);
  localparam logic [4:0] RD_COUNT  = 5'(N_ELEM);
  // OUT lingers two cycles past the last read so the final element can emerge.
  localparam logic [4:0] RD_LAST_VALID = 5'(N_ELEM + 1);

  logic [2:0] state;
  logic [3:0] load_cnt;
  logic [3:0] idx;
  logic [4:0] rd_cnt;
  logic       rd_pipe;
  logic       loading;
  logic       xfer;

  assign loading   = (state == S_IDLE) || (state == S_LOAD);
  assign b_wr_en   = loading && in_en;
  assign b_wr_addr = load_cnt;
  assign b_wr_data = b_in;
  assign upd_idx   = idx;
  assign xfer      = upd_req && upd_ack;
  assign x_rd_en   = (state == S_OUT) && (rd_cnt < RD_COUNT);
  assign x_rd_addr = rd_cnt[3:0];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      idx      <= '0;
      rd_cnt   <= '0;
      iter_cnt <= '0;
      upd_req  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_en) begin
            state    <= S_LOAD;
            load_cnt <= 4'd1;
            iter_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (in_en) begin
            if (load_cnt == LAST_IDX) begin
              state    <= S_SWEEP;
              load_cnt <= '0;
              idx      <= '0;
              iter_cnt <= '0;
              upd_req  <= 1'b1;
            end else begin
              load_cnt <= load_cnt + 4'd1;
            end
          end
        end
        S_SWEEP: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              idx      <= '0;
              iter_cnt <= iter_cnt + 8'd1;
              if (iter_cnt == LAST_ITER) begin
                upd_req <= 1'b0;
                state   <= S_DRAIN;
              end
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_DRAIN: begin
          state  <= S_OUT;
          rd_cnt <= '0;
        end
        S_OUT: begin
          if (rd_cnt == RD_LAST_VALID) begin
            state  <= S_DONE;
            rd_cnt <= '0;
          end else begin
            rd_cnt <= rd_cnt + 5'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Read data arrives one cycle after the strobe and is registered once more.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe   <= 1'b0;
      out_valid <= 1'b0;
      x_out     <= '0;
    end else begin
      rd_pipe   <= x_rd_en;
      out_valid <= rd_pipe;
      if (rd_pipe) begin
        x_out <= x_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_gsim_ctrl.sv
// Scoreboard bench for gsim_ctrl: a short-solve instance for protocol checks
// and a full-length instance checked against the linear system it solves.
module tb_gsim_ctrl;

  localparam int NE   = 16;
  localparam int NI   = 2;
  localparam int NI_L = 64;

  typedef real rvec_t [16];

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        in_en = 1'b0;
  logic [15:0] b_in = '0;
  logic        b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        upd_req;
  logic [3:0]  upd_idx;
  logic        upd_ack = 1'b0;
  logic        x_rd_en;
  logic [3:0]  x_rd_addr;
  logic [31:0] x_rd_data = '0;
  logic        out_valid;
  logic [31:0] x_out;
  logic        busy;
  logic [7:0]  iter_cnt;

  logic        in_en_l = 1'b0;
  logic [15:0] b_in_l = '0;
  logic        b_wr_en_l;
  logic [3:0]  b_wr_addr_l;
  logic [15:0] b_wr_data_l;
  logic        upd_req_l;
  logic [3:0]  upd_idx_l;
  logic        upd_ack_l = 1'b1;
  logic        x_rd_en_l;
  logic [3:0]  x_rd_addr_l;
  logic [31:0] x_rd_data_l = '0;
  logic        out_valid_l;
  logic [31:0] x_out_l;
  logic        busy_l;
  logic [7:0]  iter_cnt_l;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_bw[$];
  logic [3:0]  exp_idx[$];
  logic [7:0]  exp_iter[$];
  logic [31:0] exp_x[$];
  logic [31:0] last_exp_x = '0;
  logic [19:0] e_bw;
  logic [31:0] e_x;
  logic [7:0]  e_it;

  rvec_t x_real, b_mem, x_l, b_l;
  logic [31:0] xo_l [16];
  int    n_l = 0;
  int    ui, ui_l;
  int    cyc = 0;
  int    ack_mode = 0;
  int    ov_count = 0;
  int    ov_runs = 0;
  logic  prev_ov = 1'b0;
  logic  d1 = 1'b0, d2 = 1'b0;
  logic  rd_req = 1'b0, rd_req_l = 1'b0;
  logic [3:0] rd_a = '0, rd_a_l = '0;
  logic [7:0] prev_iter = '0;

  gsim_ctrl #(.N_ELEM(NE), .N_ITER(NI)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .upd_req(upd_req), .upd_idx(upd_idx), .upd_ack(upd_ack),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .out_valid(out_valid), .x_out(x_out), .busy(busy), .iter_cnt(iter_cnt)
  );

  gsim_ctrl #(.N_ELEM(NE), .N_ITER(NI_L)) dut_l (
    .clk(clk), .reset(reset), .in_en(in_en_l), .b_in(b_in_l),
    .b_wr_en(b_wr_en_l), .b_wr_addr(b_wr_addr_l), .b_wr_data(b_wr_data_l),
    .upd_req(upd_req_l), .upd_idx(upd_idx_l), .upd_ack(upd_ack_l),
    .x_rd_en(x_rd_en_l), .x_rd_addr(x_rd_addr_l), .x_rd_data(x_rd_data_l),
    .out_valid(out_valid_l), .x_out(x_out_l), .busy(busy_l), .iter_cnt(iter_cnt_l)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_q(real r);
    return 32'($rtoi(r * 65536.0));
  endfunction

  // One Gauss-Seidel step for the tridiagonal system 4*x[i] - x[i-1] - x[i+1] = b[i].
  function automatic real gs_val(real b, real l, real r);
    return (b + l + r) / 4.0;
  endfunction

  function automatic logic [15:0] sample(int pat, int k);
    case (pat)
      0:       return 16'(k + 1);
      1:       return 16'(k * 1000 - 7000);
      default: return (k % 2 == 1) ? 16'(-(k * 300)) : 16'(k * 250 + 5);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=%s", name, what);
  endtask

  // Emulated register files and update datapath: inputs change 1 time unit after the edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    upd_ack     = (ack_mode == 0) || (cyc % 3 == 0);
    x_rd_data   = rd_req   ? to_q(x_real[rd_a]) : 32'h0BAD_F00D;
    x_rd_data_l = rd_req_l ? to_q(x_l[rd_a_l])  : 32'h0BAD_F00D;
  end

  // Monitor for the short-solve instance: pops the scoreboard whenever the DUT presents something.
  always @(negedge clk) begin
    if (b_wr_en) begin
      b_mem[b_wr_addr] = $itor($signed(b_wr_data));
      if (exp_bw.size() == 0) begin
        failNow("b_wr_extra", $sformatf("write addr %0d data %0h required=no write", b_wr_addr, b_wr_data));
      end else begin
        e_bw = exp_bw.pop_front();
        checkOutput("b_wr", {12'd0, b_wr_addr, b_wr_data}, {12'd0, e_bw});
      end
    end
    if (upd_req) begin
      if (exp_idx.size() == 0) begin
        failNow("upd_extra", $sformatf("upd_idx %0d required=no request", upd_idx));
      end else begin
        checkOutput("upd_idx", 32'(upd_idx), 32'(exp_idx[0]));
        if (upd_ack) begin
          void'(exp_idx.pop_front());
          ui = int'(upd_idx);
          x_real[ui] = gs_val(b_mem[ui], (ui > 0) ? x_real[ui - 1] : 0.0,
                              (ui < NE - 1) ? x_real[ui + 1] : 0.0);
        end
      end
    end
    if (iter_cnt != prev_iter && iter_cnt != 8'd0) begin
      if (exp_iter.size() == 0) begin
        failNow("iter_extra", $sformatf("iter_cnt %0d required=no change", iter_cnt));
      end else begin
        e_it = exp_iter.pop_front();
        checkOutput("iter_cnt", 32'(iter_cnt), 32'(e_it));
      end
    end
    prev_iter = iter_cnt;
    if (out_valid || d2) checkOutput("ov_latency", 32'(out_valid), 32'(d2));
    d2 = d1;
    d1 = x_rd_en;
    rd_req = x_rd_en;
    rd_a   = x_rd_addr;
    if (out_valid) begin
      ov_count++;
      if (!prev_ov) ov_runs++;
      if (exp_x.size() == 0) begin
        failNow("x_out_extra", $sformatf("x_out %0h required=no output", x_out));
      end else begin
        e_x = exp_x.pop_front();
        last_exp_x = e_x;
        checkOutput("x_out", x_out, e_x);
      end
    end else if (prev_ov) begin
      checkOutput("x_out_hold", x_out, last_exp_x);
    end
    prev_ov = out_valid;
  end

  always @(negedge clk) begin
    if (b_wr_en_l) b_l[b_wr_addr_l] = $itor($signed(b_wr_data_l));
    if (upd_req_l && upd_ack_l) begin
      ui_l = int'(upd_idx_l);
      x_l[ui_l] = gs_val(b_l[ui_l], (ui_l > 0) ? x_l[ui_l - 1] : 0.0,
                         (ui_l < NE - 1) ? x_l[ui_l + 1] : 0.0);
    end
    rd_req_l = x_rd_en_l;
    rd_a_l   = x_rd_addr_l;
    if (out_valid_l && n_l < NE) begin
      xo_l[n_l] = x_out_l;
      n_l++;
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_upd_req"}, 32'(upd_req), 32'd0);
    checkOutput({tag, "_x_rd_en"}, 32'(x_rd_en), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_x_out"}, x_out, 32'd0);
    checkOutput({tag, "_iter_cnt"}, 32'(iter_cnt), 32'd0);
    checkOutput({tag, "_b_wr_addr"}, 32'(b_wr_addr), 32'd0);
  endtask

  // Loads 16 samples (with optional idle gaps) and queues every response the solve must produce.
  task automatic applyStimulus(input int pat, input int gap, input bit pulses);
    rvec_t xr, br;
    for (int i = 0; i < NE; i++) begin
      x_real[i] = 0.0;
      xr[i] = 0.0;
      br[i] = $itor($signed(sample(pat, i)));
      exp_bw.push_back({4'(i), sample(pat, i)});
    end
    for (int s = 0; s < NI; s++) begin
      for (int i = 0; i < NE; i++) begin
        xr[i] = gs_val(br[i], (i > 0) ? xr[i - 1] : 0.0, (i < NE - 1) ? xr[i + 1] : 0.0);
        exp_idx.push_back(4'(i));
      end
      exp_iter.push_back(8'(s + 1));
    end
    for (int i = 0; i < NE; i++) exp_x.push_back(to_q(xr[i]));
    for (int k = 0; k < NE; k++) begin
      in_en = 1'b1;
      b_in  = sample(pat, k);
      @(posedge clk);
      #1;
      in_en = 1'b0;
      if (k == 0) begin
        checkOutput("busy_first", 32'(busy), 32'd1);
        checkOutput("iter_clear", 32'(iter_cnt), 32'd0);
      end
      if (k < NE - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    checkOutput("upd_req_after_load", 32'(upd_req), 32'd1);
    if (pulses) begin
      for (int c = 0; c < 20; c++) begin
        in_en = (c % 2 == 0);
        b_in  = 16'hBEEF;
        @(posedge clk);
        #1;
      end
      in_en = 1'b0;
    end
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) failNow({tag, "_timeout"}, "busy still high");
    checkOutput({tag, "_iter_final"}, 32'(iter_cnt), 32'(NI));
    checkOutput({tag, "_upd_left"}, 32'(exp_idx.size()), 32'd0);
    checkOutput({tag, "_x_left"}, 32'(exp_x.size()), 32'd0);
    checkOutput({tag, "_iter_left"}, 32'(exp_iter.size()), 32'd0);
    checkOutput({tag, "_bwr_left"}, 32'(exp_bw.size()), 32'd0);
    checkOutput({tag, "_ov_count"}, 32'(ov_count), 32'd16);
    checkOutput({tag, "_ov_runs"}, 32'(ov_runs), 32'd1);
    ov_count = 0;
    ov_runs  = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic resetMidSweep();
    bit found = 1'b0;
    applyStimulus(0, 0, 1'b0);
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (upd_req && upd_idx == 4'd7 && iter_cnt == 8'd1) found = 1'b1;
    end
    checkOutput("reach_sweep1_idx7", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_idx.delete();
    exp_x.delete();
    exp_iter.delete();
    exp_bw.delete();
    last_exp_x = '0;
    ov_count = 0;
    ov_runs  = 0;
    checkResetState("midreset");
  endtask

  task automatic runLong();
    real err, row;
    real xv [16];
    int  n = 0;
    for (int k = 0; k < NE; k++) begin
      in_en_l = 1'b1;
      b_in_l  = sample(0, k);
      @(posedge clk);
      #1;
    end
    in_en_l = 1'b0;
    while (busy_l && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy_l) failNow("long_timeout", "busy still high");
    @(posedge clk);
    #1;
    checkOutput("long_iter", 32'(iter_cnt_l), 32'(NI_L));
    checkOutput("long_count", 32'(n_l), 32'd16);
    for (int i = 0; i < NE; i++) xv[i] = $itor($signed(xo_l[i])) / 65536.0;
    err = 0.0;
    for (int i = 0; i < NE; i++) begin
      row = 4.0 * xv[i] - $itor(i + 1);
      if (i > 0) row = row - xv[i - 1];
      if (i < NE - 1) row = row - xv[i + 1];
      err = err + row * row;
    end
    checks++;
    if (!(err < 1.0e-6)) begin
      errors++;
      $display("[TB] FAIL mb_err_levelA actual=%e required<1e-6", err);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    checkOutput("reset_b_wr_en", 32'(b_wr_en), 32'd0);
    checkOutput("reset_busy_l", 32'(busy_l), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] solve 1: consecutive load, ack tied high");
    ack_mode = 0;
    applyStimulus(0, 0, 1'b0);
    waitDone("solve1", 500);

    $display("[TB] solve 2: ack every third cycle");
    ack_mode = 1;
    applyStimulus(1, 0, 1'b0);
    waitDone("solve2", 1000);

    $display("[TB] solve 3: gapped load, in_en pulses during sweep");
    ack_mode = 0;
    applyStimulus(2, 2, 1'b1);
    waitDone("solve3", 500);

    $display("[TB] solve 4: reset at sweep 1 idx 7, then fresh solve");
    resetMidSweep();
    ack_mode = 1;
    applyStimulus(1, 0, 1'b0);
    waitDone("solve4", 1000);

    $display("[TB] solve 5: full-length run");
    runLong();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
